// File: rtl/l1_tag_unit_if.sv
// Request/response bundle between the LSU coalescer/refill path and the L1 tag unit.
// The master drives the lookup and refill inputs; the slave (tag unit) returns hit and latency.
interface l1_tag_unit_if;
  logic        stall;
  logic [31:0] L1TagWriteAddr;
  logic        L1TagWrite;
  logic [4:0]  SegNum;
  logic [31:0] Coalesce2L1_o;
  logic [9:0]  Delay;
  logic        L1_HIT;

  modport master (
    output stall, L1TagWriteAddr, L1TagWrite, SegNum, Coalesce2L1_o,
    input  Delay, L1_HIT
  );

  modport slave (
    input  stall, L1TagWriteAddr, L1TagWrite, SegNum, Coalesce2L1_o,
    output Delay, L1_HIT
  );
endinterface

// File: rtl/l1_tag_unit.sv
// Direct-mapped L1 data-cache tag store with a registered hit flag and a latency
// estimate scaled by the number of memory segments in the coalesced request.
module l1_tag_unit #(
  parameter int OFFSET_BITS  = 7,
  parameter int INDEX_BITS   = 5,
  parameter int HIT_LATENCY  = 2,
  parameter int MISS_LATENCY = 100,
  parameter int SEG_PENALTY  = 4
) (
  input  logic         clk,
  input  logic         reset,
  l1_tag_unit_if.slave bus
);

  localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;

  function automatic logic [9:0] sat_delay(input logic [15:0] wide);
    if (wide > 16'h03FF) begin
      sat_delay = 10'h3FF;
    end else begin
      sat_delay = wide[9:0];
    end
  endfunction

  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [SETS];
  logic [TAG_BITS-1:0] tag_d [SETS];
  logic                hit_q, hit_d;
  logic [9:0]          delay_q, delay_d;

  logic [INDEX_BITS-1:0] wr_index_s, lk_index_s;
  logic [TAG_BITS-1:0]   wr_tag_s, lk_tag_s;
  logic                  lk_hit_s;
  logic [15:0]           lk_delay_s;
  logic                  unused_offsets_s;

  assign wr_index_s = bus.L1TagWriteAddr[OFFSET_BITS +: INDEX_BITS];
  assign wr_tag_s   = bus.L1TagWriteAddr[31 -: TAG_BITS];
  assign lk_index_s = bus.Coalesce2L1_o[OFFSET_BITS +: INDEX_BITS];
  assign lk_tag_s   = bus.Coalesce2L1_o[31 -: TAG_BITS];
  assign unused_offsets_s = ^{bus.L1TagWriteAddr[OFFSET_BITS-1:0],
                              bus.Coalesce2L1_o[OFFSET_BITS-1:0]};

  // Lookup reads the array as it stood before this edge's write (read-before-write).
  always_comb begin
    lk_hit_s   = valid_q[lk_index_s] && (tag_q[lk_index_s] == lk_tag_s);
    lk_delay_s = 16'd0;
    if (lk_hit_s) begin
      lk_delay_s = 16'(HIT_LATENCY) + {11'd0, bus.SegNum};
    end else begin
      lk_delay_s = 16'(MISS_LATENCY) + ({11'd0, bus.SegNum} * 16'(SEG_PENALTY));
    end
  end

  // Next-state for the tag array and the registered outputs; stall freezes everything.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    hit_d   = hit_q;
    delay_d = delay_q;
    if (!bus.stall) begin
      if (bus.L1TagWrite) begin
        valid_d[wr_index_s] = 1'b1;
        tag_d[wr_index_s]   = wr_tag_s;
      end else begin
        valid_d = valid_q;
      end
      if (bus.Coalesce2L1_o == 32'd0) begin
        hit_d   = 1'b0;
        delay_d = 10'd0;
      end else begin
        hit_d   = lk_hit_s;
        delay_d = sat_delay(lk_delay_s);
      end
    end else begin
      hit_d   = hit_q;
      delay_d = delay_q;
    end
  end

  // State registers; reset invalidates every line and clears the outputs at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      delay_q <= 10'd0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      delay_q <= delay_d;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.L1_HIT = hit_q;
  assign bus.Delay  = delay_q;

endmodule

// File: tb/tb_l1_tag_unit.sv
// Directed and randomized bench for l1_tag_unit against a set/tag reference model.
module tb_l1_tag_unit;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  bit          m_valid [32];
  int unsigned m_tag   [32];
  logic [9:0]  prev_d;
  logic        prev_h;

  l1_tag_unit_if bus ();

  l1_tag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
  endfunction

  function automatic void model_lookup(input logic [31:0] a, input logic [4:0] seg,
                                       output logic [9:0] d, output logic h);
    int unsigned idx, tg, lat;
    idx = (a / 128) % 32;
    tg  = a / 4096;
    if (a == 32'd0) begin
      d = 10'd0; h = 1'b0;
    end else begin
      if (m_valid[idx] && m_tag[idx] == tg) begin
        h = 1'b1; lat = 2 + seg;
      end else begin
        h = 1'b0; lat = 100 + 4 * seg;
      end
      if (lat > 1023) lat = 1023;
      d = lat[9:0];
    end
  endfunction

  task automatic check(input string name, input logic [9:0] ed, input logic eh);
    compared++;
    assert (bus.Delay === ed) else begin
      mismatched++;
      $error("FAIL %s Delay observed=%0d expected=%0d", name, bus.Delay, ed);
    end
    compared++;
    assert (bus.L1_HIT === eh) else begin
      mismatched++;
      $error("FAIL %s L1_HIT observed=%0b expected=%0b", name, bus.L1_HIT, eh);
    end
  endtask

  // One clock edge: model result (or a fixed literal) is checked just after the edge.
  task automatic tick(input string name, input bit use_lit, input logic [9:0] lit_d, input logic lit_h);
    logic [9:0] ed;
    logic       eh;
    if (bus.stall) begin
      ed = prev_d; eh = prev_h;
    end else begin
      model_lookup(bus.Coalesce2L1_o, bus.SegNum, ed, eh);
      if (bus.L1TagWrite) begin
        m_valid[(bus.L1TagWriteAddr / 128) % 32] = 1'b1;
        m_tag[(bus.L1TagWriteAddr / 128) % 32]   = bus.L1TagWriteAddr / 4096;
      end
    end
    if (use_lit) begin
      ed = lit_d; eh = lit_h;
    end
    @(posedge clk);
    #1;
    check(name, ed, eh);
    prev_d = ed;
    prev_h = eh;
  endtask

  task automatic drive(input logic st, input logic wr, input logic [31:0] waddr,
                       input logic [31:0] laddr, input logic [4:0] seg);
    bus.stall          = st;
    bus.L1TagWrite     = wr;
    bus.L1TagWriteAddr = waddr;
    bus.Coalesce2L1_o  = laddr;
    bus.SegNum         = seg;
  endtask

  logic [31:0] pool [8];

  initial begin
    model_clear();
    prev_d = 10'd0; prev_h = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    reset = 1'b1;
    #1;
    check("reset_state", 10'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAAA, 5'd5);
    tick("cold_miss", 1'b1, 10'd120, 1'b0);
    drive(1'b0, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 5'd0);
    tick("write_edge_miss", 1'b1, 10'd100, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAAA, 5'd0);
    tick("next_edge_hit", 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAEA, 5'd3);
    tick("same_line_offset", 1'b1, 10'd5, 1'b1);
    drive(1'b0, 1'b1, 32'hAAAAABEA, 32'hAAAAAAEA, 5'd3);
    tick("install_idx23", 1'b1, 10'd5, 1'b1);
    drive(1'b0, 1'b1, 32'hAAAAAFEA, 32'hAAAAAAEA, 5'd3);
    tick("install_idx31", 1'b1, 10'd5, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAFEA, 5'd0);
    tick("hit_idx31", 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAABEA, 5'd1);
    tick("hit_idx23", 1'b1, 10'd3, 1'b1);
    drive(1'b0, 1'b1, 32'hBBBBAFEA, 32'hAAAAAFEA, 5'd0);
    tick("conflict_rbw", 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAFEA, 5'd0);
    tick("conflict_miss", 1'b1, 10'd100, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd9);
    tick("idle_zero", 1'b1, 10'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAAA, 5'd0);
    tick("pre_stall_hit", 1'b1, 10'd2, 1'b1);
    drive(1'b1, 1'b1, 32'h12345000, 32'h12345000, 5'd7);
    tick("stall_hold", 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 32'h12345000, 5'd7);
    tick("stall_no_write", 1'b1, 10'd128, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 32'h77777000, 5'd31);
    tick("max_seg_miss", 1'b1, 10'd224, 1'b0);

    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAAA, 5'd0);
    tick("pre_reset_hit", 1'b1, 10'd2, 1'b1);
    drive(1'b0, 1'b1, 32'h55555000, 32'h55555000, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 10'd0, 1'b0);
    model_clear();
    prev_d = 10'd0; prev_h = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'h55555000, 5'd0);
    tick("inflight_discarded", 1'b1, 10'd100, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 32'hAAAAAAAA, 5'd2);
    tick("reset_invalidates", 1'b1, 10'd108, 1'b0);

    // Small address pool with shared indices so hits, conflicts and overwrites all occur.
    for (int i = 0; i < 8; i++) begin
      pool[i] = {$urandom_range(3, 0) == 0 ? 20'hAAAAA : 20'($urandom_range(7, 1)),
                 5'($urandom_range(3, 0)), 7'd0};
    end
    for (int n = 0; n < 400; n++) begin
      logic [31:0] la, wa;
      wa = pool[$urandom_range(7, 0)] | 32'($urandom_range(127, 0));
      la = ($urandom_range(9, 0) == 0) ? 32'd0 : (pool[$urandom_range(7, 0)] | 32'($urandom_range(127, 0)));
      drive(($urandom_range(7, 0) == 0), ($urandom_range(2, 0) == 0), wa, la, 5'($urandom_range(31, 0)));
      tick("random", 1'b0, 10'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/l1_tag_unit.md
Name: l1_tag_unit

Overview:
- Tag store and hit/latency estimator for the L1 data cache in the load/store unit.
- Holds a direct-mapped array of line tags, which is filled by tag-write requests from the refill path.
- Checks each coalesced request address from the coalescer against the array.
- Reports a registered hit flag and the access latency (cycles) for the request, scaled by the number of memory segments.

Parameters:
- OFFSET_BITS, 7, log2 line size in bytes (128 B lines).
- INDEX_BITS, 5, log2 number of sets (32 entries).
- HIT_LATENCY, 2, base Delay reported on a hit.
- MISS_LATENCY, 100, base Delay reported on a miss.
- SEG_PENALTY, 4, extra Delay cycles per segment on a miss.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all state and outputs.
- L1TagWriteAddr  in  32  byte address of the line being installed.
- L1TagWrite  in  1  tag write enable.
- SegNum  in  5  number of segments in the current coalesced request (0..31).
- Coalesce2L1_o  in  32  lookup byte address from the coalescer; 0 = idle.
- Delay  out  10  registered latency estimate for the last sampled request.
- L1_HIT  out  1  registered hit flag for the last sampled request.

Behaviour:
- Address split:
  - offset = [6:0]
  - index = [11:7]
  - tag = [31:12]
  - With the default parameters the tag is 20 bits wide. In general, index = [OFFSET_BITS+INDEX_BITS-1 : OFFSET_BITS] and tag = the remaining upper bits.
- Storage: 2^INDEX_BITS entries, each holding {valid, tag}.
- Reset (async, reset=1):
  - All valid bits cleared.
  - L1_HIT=0, Delay=0.
  - Takes effect immediately, including mid-operation. Any in-flight write is discarded.
- Tag write: on a rising clk with L1TagWrite=1 and stall=0, entry[index(L1TagWriteAddr)] <= {1, tag(L1TagWriteAddr)}. This overwrites the previous occupant (no eviction signalling).
- Lookup: on each rising clk with stall=0, Coalesce2L1_o is sampled.
  - Idle: address == 0 -> L1_HIT<=0, Delay<=0.
  - Hit: entry[index] valid and stored tag == tag(address) -> L1_HIT<=1, Delay<=HIT_LATENCY+SegNum.
  - Miss: otherwise -> L1_HIT<=0, Delay<=MISS_LATENCY+SegNum*SEG_PENALTY.
- Latency: outputs change at the same edge that samples the inputs (one registered stage). The lookup is combinational on the array, then registered.
- Write/lookup in the same cycle to the same index: the lookup sees the array contents before the write (read-before-write). The new line hits from the next edge on.
- Addresses with different offsets in the same line hit identically.
- Arithmetic:
  - Delay is computed at 11+ bits, then saturated to 10'h3FF.
  - With the default parameters the maximum is 100+31*4=224, so no saturation occurs.
- stall=1:
  - No tag write.
  - L1_HIT and Delay hold their values.
  - The array is unchanged.
- No other state; no FSM.

Test Plan:
- Apply reset pulse -> L1_HIT=0 and Delay=0 immediately (asynchronously), and all entries invalid: a lookup of 0xAAAAAAAA after reset gives L1_HIT=0, Delay=100+SegNum*4.
- Hold Coalesce2L1_o=0xAAAAAAAA and SegNum=0. Write 0xAAAAAAAA with L1TagWrite=1 at edge N:
  - Edge N lookup -> miss, Delay=100.
  - Edge N+1 -> L1_HIT=1, Delay=2.
- After installing 0xAAAAAAAA, look up 0xAAAAAAEA (same line, different offset) with SegNum=3 -> L1_HIT=1, Delay=5.
- Write 0xAAAAABEA (index 23) and 0xAAAAAFEA (index 31), then look up 0xAAAAAFEA -> hit.
- Conflict case: write 0xBBBBAFEA (same index 31, different tag), then look up 0xAAAAAFEA -> miss.
- Drive Coalesce2L1_o=0 -> L1_HIT=0, Delay=0.
- Stall case: assert stall while L1TagWrite=1 for a new line and the lookup address changes -> outputs hold their prior values, and the later lookup of that line misses.
- Miss with SegNum=31 -> Delay=224.
